// File: rtl/dmux_pkg.sv
// dmux_pkg: shared widths and word type for the 8-way buffered demultiplexer
package dmux_pkg;
    localparam int WIDTH    = 16;
    localparam int SEL_BITS = 3;
    localparam int CHANNELS = 2 ** SEL_BITS;
    typedef logic [WIDTH-1:0] word_t;
endpackage

// File: rtl/dmux_channel.sv
// dmux_channel: one-entry valid/ready holding register for a single output channel
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   load, load_data   : write a new word (caller guarantees can_load)
//   out_ready         : consumer accepts the held word this cycle
//   out_valid/out_data: holding register full flag and contents
//   can_load          : empty, or draining this cycle
module dmux_channel
    import dmux_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    output logic         can_load
);
    logic         full_q, full_d;
    logic [W-1:0] buf_q, buf_d;

    assign can_load  = ~full_q | out_ready;
    assign out_valid = full_q;
    assign out_data  = buf_q;

    // A load always wins over a drain, so simultaneous load+drain keeps full set.
    // On a plain drain the stale word stays in buf_q.
    always_comb begin
        full_d = load | (full_q & ~out_ready);
        buf_d  = load ? load_data : buf_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            full_q <= 1'b0;
            buf_q  <= '0;
        end else begin
            full_q <= full_d;
            buf_q  <= buf_d;
        end
    end
endmodule

// File: rtl/dmux8way16_buffer.sv
// dmux8way16_buffer: registered 8-way demultiplexer with per-channel one-entry buffers
//   clock, reset                 : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready/in_data    : producer stream, in_sel picks the destination channel
//   out_valid/out_ready/out_data : per-channel consumer handshakes, channel i at [i*WIDTH +: WIDTH]
//   count                        : words accepted, modulo 2^16
module dmux8way16_buffer #(
    parameter int WIDTH    = dmux_pkg::WIDTH,
    parameter int SEL_BITS = dmux_pkg::SEL_BITS,
    localparam int CHANNELS = 2 ** SEL_BITS
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [WIDTH-1:0]          in_data,
    input  logic [SEL_BITS-1:0]       in_sel,
    output logic [CHANNELS-1:0]       out_valid,
    input  logic [CHANNELS-1:0]       out_ready,
    output logic [CHANNELS*WIDTH-1:0] out_data,
    output logic [15:0]               count
);
    logic [CHANNELS-1:0] can_load, load;
    logic                acc;
    logic [15:0]         count_q, count_d;

    // in_ready depends only on the selected channel, so a blocked channel never
    // stalls words headed elsewhere.
    assign in_ready = can_load[in_sel];
    assign acc      = in_valid & in_ready;
    assign load     = acc ? CHANNELS'(1) << in_sel : '0;
    assign count    = count_q;

    always_comb count_d = count_q + 16'(acc);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        dmux_channel #(.W(WIDTH)) u_ch (
            .clock     (clock),
            .reset     (reset),
            .load      (load[i]),
            .load_data (in_data),
            .out_ready (out_ready[i]),
            .out_valid (out_valid[i]),
            .out_data  (out_data[i*WIDTH +: WIDTH]),
            .can_load  (can_load[i])
        );
    end
endmodule

// File: tb/tb_dmux8way16_buffer.sv
// tb_dmux8way16_buffer: randomized and directed checks against a behavioural model
module tb_dmux8way16_buffer;
    import dmux_pkg::*;

    logic         clock, reset, in_valid, in_ready;
    word_t        in_data;
    logic [2:0]   in_sel;
    logic [7:0]   out_valid, out_ready;
    logic [127:0] out_data;
    logic [15:0]  count;

    int total = 0;
    int bad   = 0;

    logic [7:0]  m_full;
    word_t       m_buf[8];
    logic [15:0] m_count;
    word_t       cons0[$];

    dmux8way16_buffer dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    function automatic logic [127:0] m_data();
        logic [127:0] r;
        for (int i = 0; i < 8; i++) r[i*16 +: 16] = m_buf[i];
        return r;
    endfunction

    function automatic logic m_ready();
        return !m_full[in_sel] || out_ready[in_sel];
    endfunction

    task automatic m_clear();
        m_full  = '0;
        m_count = '0;
        for (int i = 0; i < 8; i++) m_buf[i] = '0;
        cons0.delete();
    endtask

    // Advance one clock: the model applies the handshake rules, then the DUT edge occurs.
    task automatic cycle();
        logic acc;
        acc = in_valid && m_ready();
        for (int i = 0; i < 8; i++)
            if (m_full[i] && out_ready[i]) begin
                if (i == 0) cons0.push_back(m_buf[0]);
                m_full[i] = 1'b0;
            end
        if (acc) begin
            m_buf[in_sel]  = in_data;
            m_full[in_sel] = 1'b1;
            m_count        = m_count + 16'd1;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sel    = '0;
        in_data   = '0;
        out_ready = '0;
        @(posedge clock);
        #1;
        reset = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL reset_valid got=%h exp=00", out_valid); end
        total++; if (out_data !== 128'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", out_data); end
        total++; if (count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", count); end
        for (int s = 0; s < 8; s++) begin
            in_sel = 3'(s);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready sel=%0d got=%b exp=1", s, in_ready); end
        end
        in_sel = '0;
        cycle();
        total++; if (out_valid !== 8'h00 || count !== 16'h0) begin bad++; $display("FAIL idle got=%h/%h exp=00/0000", out_valid, count); end
    endtask

    task automatic test_hold();
        in_valid = 1'b1; in_sel = 3'd3; in_data = 16'hA5A5; out_ready = '0;
        cycle();
        total++; if (out_valid !== 8'h08) begin bad++; $display("FAIL hold_valid got=%h exp=08", out_valid); end
        total++; if (out_data[3*16 +: 16] !== 16'hA5A5) begin bad++; $display("FAIL hold_slice3 got=%h exp=a5a5", out_data[3*16 +: 16]); end
        total++; if (count !== 16'd1) begin bad++; $display("FAIL hold_count got=%h exp=0001", count); end
        in_data = 16'h5555;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hold_ready3 got=%b exp=0", in_ready); end
        cycle();
        total++; if (out_data[3*16 +: 16] !== 16'hA5A5 || count !== 16'd1) begin bad++; $display("FAIL hold_kept got=%h/%h exp=a5a5/0001", out_data[3*16 +: 16], count); end
        in_valid = 1'b0;
        cycle();
        in_valid = 1'b1; in_sel = 3'd5; in_data = 16'h1234;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_ready5 got=%b exp=1", in_ready); end
        cycle();
        in_valid = 1'b0;
        total++; if (out_valid !== 8'h28) begin bad++; $display("FAIL hold_valid2 got=%h exp=28", out_valid); end
        total++; if (out_data !== m_data()) begin bad++; $display("FAIL hold_data got=%h exp=%h", out_data, m_data()); end
        in_sel = 3'd0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hold_nohol got=%b exp=1", in_ready); end
    endtask

    task automatic test_stream();
        do_reset();
        out_ready = 8'h01;
        in_sel    = 3'd0;
        in_valid  = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            in_data = 16'(k);
            #1;
            total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready k=%0d got=%b exp=1", k, in_ready); end
            cycle();
            total++; if (out_valid[0] !== 1'b1 || out_data[15:0] !== 16'(k)) begin bad++; $display("FAIL stream_out k=%0d got=%b/%h exp=1/%h", k, out_valid[0], out_data[15:0], 16'(k)); end
        end
        in_valid = 1'b0;
        cycle();
        total++; if (count !== 16'd16) begin bad++; $display("FAIL stream_count got=%h exp=0010", count); end
        total++; if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL stream_drained got=%b exp=0", out_valid[0]); end
        total++; if (cons0.size() != 16) begin bad++; $display("FAIL stream_nwords got=%0d exp=16", cons0.size()); end
        for (int k = 0; k < cons0.size(); k++)
            if (cons0[k] !== 16'(k + 1)) begin
                total++; bad++; $display("FAIL stream_order idx=%0d got=%h exp=%h", k, cons0[k], 16'(k + 1));
            end
        out_ready = '0;
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; in_sel = 3'd7; in_data = 16'h1111; out_ready = '0;
        cycle();
        out_ready = 8'h80; in_data = 16'hBEEF;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready got=%b exp=1", in_ready); end
        total++; if (out_data[7*16 +: 16] !== 16'h1111) begin bad++; $display("FAIL b2b_old got=%h exp=1111", out_data[7*16 +: 16]); end
        cycle();
        in_valid = 1'b0; out_ready = '0;
        total++; if (out_valid[7] !== 1'b1 || out_data[7*16 +: 16] !== 16'hBEEF) begin bad++; $display("FAIL b2b_new got=%b/%h exp=1/beef", out_valid[7], out_data[7*16 +: 16]); end
        total++; if (count !== m_count) begin bad++; $display("FAIL b2b_count got=%h exp=%h", count, m_count); end
    endtask

    task automatic test_wrap();
        do_reset();
        out_ready = 8'hFF; in_valid = 1'b1; in_sel = 3'd1;
        for (int k = 0; k < 65535; k++) begin
            in_data = 16'(k);
            cycle();
        end
        total++; if (count !== 16'hFFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffff", count); end
        in_data = 16'hC0DE;
        cycle();
        in_valid = 1'b0;
        total++; if (count !== 16'h0000) begin bad++; $display("FAIL wrap_count got=%h exp=0000", count); end
        total++; if (out_data[31:16] !== 16'hC0DE) begin bad++; $display("FAIL wrap_data got=%h exp=c0de", out_data[31:16]); end
        out_ready = '0;
        cycle();
    endtask

    task automatic test_async_reset();
        out_ready = '0; in_valid = 1'b1;
        in_sel = 3'd2; in_data = 16'h2222; cycle();
        in_sel = 3'd6; in_data = 16'h6666; cycle();
        in_valid = 1'b0;
        total++; if (out_valid[2] !== 1'b1 || out_valid[6] !== 1'b1) begin bad++; $display("FAIL areset_pre got=%h exp=44", out_valid); end
        #3;
        reset = 1'b1;
        #1;
        m_clear();
        total++; if (out_valid !== 8'h00) begin bad++; $display("FAIL areset_valid got=%h exp=00", out_valid); end
        total++; if (count !== 16'h0 || out_data !== 128'h0) begin bad++; $display("FAIL areset_state got=%h/%h exp=0/0", count, out_data); end
        #2;
        reset = 1'b0;
        in_valid = 1'b1; in_sel = 3'd2; in_data = 16'h7777;
        cycle();
        in_valid = 1'b0;
        total++; if (out_valid !== 8'h04 || out_data[2*16 +: 16] !== 16'h7777 || count !== 16'd1) begin bad++; $display("FAIL areset_after got=%h/%h/%h exp=04/7777/0001", out_valid, out_data[2*16 +: 16], count); end
    endtask

    task automatic test_random();
        logic acc;
        in_valid = 1'b0;
        for (int n = 0; n < 400; n++) begin
            out_ready = 8'($urandom);
            #1;
            total++; if (in_ready !== m_ready()) begin bad++; $display("FAIL rand_ready n=%0d got=%b exp=%b", n, in_ready, m_ready()); end
            acc = in_valid && m_ready();
            cycle();
            total++; if (out_valid !== m_full || out_data !== m_data() || count !== m_count) begin bad++; $display("FAIL rand_state n=%0d got=%h/%h/%h exp=%h/%h/%h", n, out_valid, out_data, count, m_full, m_data(), m_count); end
            if (!(in_valid && !acc)) begin
                in_valid = $urandom_range(0, 3) != 0;
                in_sel   = 3'($urandom);
                in_data  = 16'($urandom);
            end
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_hold();
        test_stream();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
